multibit_tree_layer_mem: RTL and testbench
==========================================

# multibit_tree_layer_mem

Parametrised bitmap memory for one layer of the multibit-tree tag sorter. Holds 2**N nodes of W occupancy bits each. Provides two registered read ports for the tree-walk lookup and one read-modify-write update port that can both set and clear bits, so the layer serves enqueue and dequeue. It also clears itself after reset with a sweep state machine, so it does not depend on simulation-only initialisation.

## Interface
- W, 16, bits per node (one bit per child); W >= 1
- N, 4, address width; depth = 2**N; N >= 1
- ROOT_INIT, 1, value loaded into node 0 during the init sweep; all other nodes load 0
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- busy  out  1  high while the init sweep runs
- rd_en  in  1  read request, both ports
- rd_addr_a  in  N  read address, port A
- rd_addr_b  in  N  read address, port B
- rd_data_a  out  W  node value, port A
- rd_data_b  out  W  node value, port B
- rd_valid  out  1  rd_data_a/b hold the result of an accepted read
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted this cycle; equals !busy
- upd_addr  in  N  node to update
- upd_set  in  W  bits to set
- upd_clr  in  W  bits to clear

## Operation
- State machine with two states: INIT and RUN.
- **INIT**
  - Entered on every cycle with rst high, including reset mid-operation. The sweep always restarts at address 0.
  - Sweep counter cnt (N+1 bits) writes one node per cycle: node 0 gets ROOT_INIT; every other node gets 0.
  - After node 2**N-1 is written, the FSM moves to RUN.
  - busy = 1. upd_ready = 0. Updates and reads are dropped.
- **RUN**
  - busy = 0. upd_ready = 1.
- **Update** (accepted when upd_valid && upd_ready):
  - At the clock edge: MEM[upd_addr] <= (MEM[upd_addr] & ~upd_clr) | upd_set.
  - Where upd_set and upd_clr overlap, set wins.
  - Zero masks leave the node unchanged.
- **Read** (accepted when rd_en && !busy):
  - Each port registers MEM[addr] with write forwarding.
  - If an accepted update targets the same address in the same cycle, the port returns the post-update value (old & ~clr) | set.
  - Both ports may read the same address.
  - Forwarding is evaluated independently per port.
- **Read not accepted:** rd_data_a/b hold their previous values; rd_valid = 0 on the next cycle.
- **Reset values:** rd_data_a = 0, rd_data_b = 0, rd_valid = 0, busy = 1, upd_ready = 0, cnt = 0, state = INIT.
- **Masks:** all arithmetic is bitwise on W bits; no carries. The counter terminal compare is cnt == 2**N - 1.

## Timing
- Init sweep: rst deasserts at edge k; busy stays high for exactly 2**N cycles after it; busy = 0 at edge k + 2**N.
- Read latency is 1 cycle: address sampled at edge t; rd_data and rd_valid are valid after edge t.
- rd_valid is a one-cycle pulse per accepted read; back-to-back reads give a continuous rd_valid.
- An update at edge t is visible to:
  - a read sampled at edge t, via forwarding;
  - any later read, via memory.
- Consecutive updates to the same address on consecutive cycles compose exactly; there is no lost update.
- Reads and updates may occur every cycle; there is no stall in RUN.

## Structure
- Shared package mbt_pkg:
  - default W and N;
  - state encoding (INIT, RUN);
  - function apply_mask(old, set, clr) returning (old & ~clr) | set, shared by the write path and the forwarding path.
- Sub-module mbt_init_sweep: holds the FSM and counter; outputs busy, sweep address, sweep data and sweep write-enable.
- The top module muxes between the sweep write path and the update write path, and holds the two registered read ports.
- Memory is an array of 2**N x W. The read ports are registered so the array can map to distributed RAM.

## Test plan
- Reset with W=16, N=4:
  - busy is high for 16 cycles, then low.
  - Read addresses 0 and 5: rd_data_a = 0x0001, rd_data_b = 0x0000, rd_valid = 1 for one cycle.
- Update addr 3 with set = 0x00F0, clr = 0, then read A = 3 on the next cycle -> rd_data_a = 0x00F0.
- Same-cycle forwarding:
  - Setup: node 3 = 0x00F0.
  - Stimulus: update addr 3 with set = 0x0001, clr = 0x0030, and in the same cycle read A = 3, B = 3.
  - Response: rd_data_a = rd_data_b = 0x00C1.
- Set/clear overlap: update addr 7 with set = 0x0101, clr = 0xFFFF -> a later read of 7 returns 0x0101.
- Back-to-back updates:
  - Stimulus: addr 9 with set = 0x0002, then addr 9 with set = 0x0004, then addr 9 with clr = 0x0002, on consecutive cycles.
  - Response: a read of 9 returns 0x0004.
- Reset mid-operation:
  - Stimulus: populate nodes 1..15, assert rst for 1 cycle, and drive upd_valid and rd_en during the sweep.
  - Response: upd_ready = 0 and rd_valid = 0 throughout; after busy falls, all nodes read 0 except node 0 = 0x0001.

Source files
------------

// File: rtl/mbt_pkg.sv
// Shared types and helpers for one multibit-tree layer memory.
// Holds default geometry, FSM encoding and the node update rule.
package mbt_pkg;

    localparam int W_DEF  = 16;
    localparam int N_DEF  = 4;
    localparam int MASK_W = 64;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    // Operands are widened to MASK_W so one function serves any W up to 64.
    function automatic logic [MASK_W-1:0] apply_mask(
        input logic [MASK_W-1:0] old,
        input logic [MASK_W-1:0] set,
        input logic [MASK_W-1:0] clr
    );
        return (old & ~clr) | set;
    endfunction

endpackage

// File: rtl/multibit_tree_layer_mem_if.sv
// Read and update bundle for the multibit-tree layer memory.
// The master drives requests; the slave returns data and status.
interface multibit_tree_layer_mem_if #(
    parameter int W = 16,
    parameter int N = 4
) ();
    logic         busy;
    logic         rd_en;
    logic [N-1:0] rd_addr_a;
    logic [N-1:0] rd_addr_b;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;
    logic         rd_valid;
    logic         upd_valid;
    logic         upd_ready;
    logic [N-1:0] upd_addr;
    logic [W-1:0] upd_set;
    logic [W-1:0] upd_clr;

    modport master (
        input  busy, rd_data_a, rd_data_b, rd_valid, upd_ready,
        output rd_en, rd_addr_a, rd_addr_b,
        output upd_valid, upd_addr, upd_set, upd_clr
    );

    modport slave (
        output busy, rd_data_a, rd_data_b, rd_valid, upd_ready,
        input  rd_en, rd_addr_a, rd_addr_b,
        input  upd_valid, upd_addr, upd_set, upd_clr
    );
endinterface

// File: rtl/mbt_init_sweep.sv
// Post-reset sweep: walks every node once, loading the root value
// into node 0 and zero elsewhere, then hands the memory over.
module mbt_init_sweep
    import mbt_pkg::*;
#(
    parameter int           W         = W_DEF,
    parameter int           N         = N_DEF,
    parameter logic [W-1:0] ROOT_INIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic         busy,
    output logic [N-1:0] sw_addr,
    output logic [W-1:0] sw_data,
    output logic         sw_we
);
    localparam logic [N:0] LAST = (N+1)'((1 << N) - 1);

    state_t     state;
    logic [N:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign sw_we   = (state == S_INIT) && !rst;
    assign sw_addr = cnt[N-1:0];
    assign sw_data = (cnt == '0) ? ROOT_INIT : '0;

endmodule

// File: rtl/multibit_tree_layer_mem.sv
// Occupancy bitmap for one tree layer: two registered read ports with
// same-cycle update forwarding and a set/clear read-modify-write port.
module multibit_tree_layer_mem
    import mbt_pkg::*;
#(
    parameter int           W         = W_DEF,
    parameter int           N         = N_DEF,
    parameter logic [W-1:0] ROOT_INIT = 1
) (
    input logic                      clk,
    input logic                      rst,
    multibit_tree_layer_mem_if.slave bus
);
    localparam int DEPTH = 1 << N;

    logic [W-1:0] mem [DEPTH];

    logic         busy;
    logic [N-1:0] sw_addr;
    logic [W-1:0] sw_data;
    logic         sw_we;
    logic         upd_acc;
    logic         rd_acc;
    logic [W-1:0] upd_new;

    mbt_init_sweep #(
        .W         (W),
        .N         (N),
        .ROOT_INIT (ROOT_INIT)
    ) u_sweep (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .sw_addr (sw_addr),
        .sw_data (sw_data),
        .sw_we   (sw_we)
    );

    assign bus.busy      = busy;
    assign bus.upd_ready = !busy;

    assign upd_acc = bus.upd_valid && !busy;
    assign rd_acc  = bus.rd_en && !busy;

    assign upd_new = W'(apply_mask(MASK_W'(mem[bus.upd_addr]),
                                   MASK_W'(bus.upd_set),
                                   MASK_W'(bus.upd_clr)));

    always_ff @(posedge clk) begin
        if (sw_we) begin
            mem[sw_addr] <= sw_data;
        end else if (upd_acc) begin
            mem[bus.upd_addr] <= upd_new;
        end
    end

    // Each port forwards independently so a walk sees its own update.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data_a <= '0;
            bus.rd_data_b <= '0;
            bus.rd_valid  <= 1'b0;
        end else begin
            bus.rd_valid <= rd_acc;
            if (rd_acc) begin
                bus.rd_data_a <= (upd_acc && bus.upd_addr == bus.rd_addr_a)
                               ? upd_new : mem[bus.rd_addr_a];
                bus.rd_data_b <= (upd_acc && bus.upd_addr == bus.rd_addr_b)
                               ? upd_new : mem[bus.rd_addr_b];
            end
        end
    end

endmodule

// File: tb/tb_multibit_tree_layer_mem.sv
// Scoreboard bench for the layer memory: reads push expectations,
// a negedge monitor pops and compares whenever rd_valid is seen.
module tb_multibit_tree_layer_mem;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   rd_id = 0;
    exp_t sb[$];

    multibit_tree_layer_mem_if #(.W(W), .N(N)) bus ();

    multibit_tree_layer_mem #(
        .W(W), .N(N), .ROOT_INIT(16'h0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.rd_data_a !== e.a) begin
                    errors++;
                    $display("FAIL rd_a#%0d: got %h expected %h",
                             e.id, bus.rd_data_a, e.a);
                end
                checks++;
                if (bus.rd_data_b !== e.b) begin
                    errors++;
                    $display("FAIL rd_b#%0d: got %h expected %h",
                             e.id, bus.rd_data_b, e.b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en     = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_set   = '0;
        bus.upd_clr   = '0;
    endtask

    task automatic push_rd(input logic [N-1:0] aa, input logic [N-1:0] ab,
                           input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_t e;
        bus.rd_en     = 1'b1;
        bus.rd_addr_a = aa;
        bus.rd_addr_b = ab;
        e.a  = ea;
        e.b  = eb;
        e.id = rd_id++;
        sb.push_back(e);
    endtask

    task automatic set_upd(input logic [N-1:0] ad, input logic [W-1:0] s,
                           input logic [W-1:0] c);
        bus.upd_valid = 1'b1;
        bus.upd_addr  = ad;
        bus.upd_set   = s;
        bus.upd_clr   = c;
    endtask

    task automatic rd(input logic [N-1:0] aa, input logic [N-1:0] ab,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
        push_rd(aa, ab, ea, eb);
        tick();
        idle();
    endtask

    task automatic upd(input logic [N-1:0] ad, input logic [W-1:0] s,
                       input logic [W-1:0] c);
        set_upd(ad, s, c);
        tick();
        idle();
    endtask

    task automatic wait_sweep(input string name, input bit drive);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            if (drive) begin
                chk({name, "_upd_ready"}, 32'(bus.upd_ready), 32'd0);
                chk({name, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
            end
            tick();
            n++;
        end
        idle();
        chk({name, "_busy_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.upd_addr  = '0;
        idle();
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_a", 32'(bus.rd_data_a), 32'd0);
        chk("rst_rd_b", 32'(bus.rd_data_b), 32'd0);
        rst = 1'b0;
        wait_sweep("init", 1'b0);
        chk("run_upd_ready", 32'(bus.upd_ready), 32'd1);

        rd(4'd0, 4'd5, 16'h0001, 16'h0000);
        tick();
        chk("rd_pulse", 32'(bus.rd_valid), 32'd0);
        chk("rd_hold_a", 32'(bus.rd_data_a), 32'h0001);

        upd(4'd3, 16'h00F0, 16'h0000);
        rd(4'd3, 4'd0, 16'h00F0, 16'h0001);

        set_upd(4'd3, 16'h0001, 16'h0030);
        push_rd(4'd3, 4'd3, 16'h00C1, 16'h00C1);
        tick();
        idle();
        rd(4'd3, 4'd4, 16'h00C1, 16'h0000);

        set_upd(4'd5, 16'h8000, 16'h0000);
        push_rd(4'd5, 4'd6, 16'h8000, 16'h0000);
        tick();
        idle();

        upd(4'd7, 16'h0101, 16'hFFFF);
        rd(4'd7, 4'd5, 16'h0101, 16'h8000);

        upd(4'd9, 16'h0002, 16'h0000);
        upd(4'd9, 16'h0004, 16'h0000);
        upd(4'd9, 16'h0000, 16'h0002);
        rd(4'd9, 4'd9, 16'h0004, 16'h0004);

        upd(4'd5, 16'h0000, 16'h0000);
        push_rd(4'd5, 4'd0, 16'h8000, 16'h0001);
        tick();
        push_rd(4'd9, 4'd7, 16'h0004, 16'h0101);
        tick();
        idle();
        tick();

        for (int i = 1; i < 16; i++) begin
            upd(4'(i), 16'(i) | 16'h5A00, 16'h0000);
        end
        rd(4'd15, 4'd1, 16'h5A0F, 16'h5A01);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_upd(4'd0, 16'hFFFF, 16'h0000);
        bus.rd_en     = 1'b1;
        bus.rd_addr_a = 4'd2;
        bus.rd_addr_b = 4'd3;
        wait_sweep("mid", 1'b1);

        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i),
               (i == 0) ? 16'h0001 : 16'h0000,
               (i == 15) ? 16'h0001 : 16'h0000);
        end

        for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
